// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute pipeline boundary: field widths, the
// decoded control bundle and the full ID/EX register payload.
package pipe_pkg;

  localparam int ALU_CMD_W = 4;
  localparam int REG_IDX_W = 4;
  localparam int WORD_W    = 32;
  localparam int BIMM_W    = 24;
  localparam int SHOP_W    = 12;

  typedef struct packed {
    logic                 status_en;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 branch;
    logic                 imm;
    logic [ALU_CMD_W-1:0] alu_cmd;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

  typedef struct packed {
    logic                 valid;
    id_ex_ctrl_t          ctrl;
    logic [WORD_W-1:0]    pc;
    logic [WORD_W-1:0]    reg1;
    logic [WORD_W-1:0]    reg2;
    logic [REG_IDX_W-1:0] dest;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic [BIMM_W-1:0]    b_signed_imm;
    logic [SHOP_W-1:0]    shifter_operand;
    logic                 carry;
  } id_ex_bundle_t;

  // A flushed slot: no control effects and marked invalid.
  localparam id_ex_bundle_t ID_EX_BUNDLE_BUBBLE = '{
    valid:           1'b0,
    ctrl:            ID_EX_BUBBLE,
    pc:              '0,
    reg1:            '0,
    reg2:            '0,
    dest:            '0,
    src1:            '0,
    src2:            '0,
    b_signed_imm:    '0,
    shifter_operand: '0,
    carry:           1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Event counter that counts up on inc and sticks at its maximum value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_sat;

  assign w_sat = &r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (inc && !w_sat)
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, branch flush and saturating
// stall/flush event counters for debug.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [WORD_W-1:0]    pc_in,
  input  logic [WORD_W-1:0]    reg1_in,
  input  logic [WORD_W-1:0]    reg2_in,
  input  logic [ALU_CMD_W-1:0] alu_cmd_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [REG_IDX_W-1:0] src1_in,
  input  logic [REG_IDX_W-1:0] src2_in,
  input  logic                 status_en_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 wb_en_in,
  input  logic                 branch_in,
  input  logic                 imm_in,
  input  logic [BIMM_W-1:0]    b_signed_imm_in,
  input  logic [SHOP_W-1:0]    shifter_operand_in,
  input  logic                 carry_in,
  output logic [WORD_W-1:0]    pc,
  output logic [WORD_W-1:0]    reg1,
  output logic [WORD_W-1:0]    reg2,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic [REG_IDX_W-1:0] dest,
  output logic [REG_IDX_W-1:0] src1,
  output logic [REG_IDX_W-1:0] src2,
  output logic                 status_en,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 branch,
  output logic                 imm,
  output logic [BIMM_W-1:0]    b_signed_imm,
  output logic [SHOP_W-1:0]    shifter_operand,
  output logic                 carry,
  output logic                 valid,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  id_ex_bundle_t r_bundle;
  id_ex_bundle_t w_load;
  logic          w_stall_inc;

  // Decode bubbles (zeroed control bits) still load as valid; valid only
  // tracks this register's own flush.
  always_comb begin
    w_load                   = '0;
    w_load.valid             = 1'b1;
    w_load.ctrl.status_en    = status_en_in;
    w_load.ctrl.mem_read     = mem_read_in;
    w_load.ctrl.mem_write    = mem_write_in;
    w_load.ctrl.wb_en        = wb_en_in;
    w_load.ctrl.branch       = branch_in;
    w_load.ctrl.imm          = imm_in;
    w_load.ctrl.alu_cmd      = alu_cmd_in;
    w_load.pc                = pc_in;
    w_load.reg1              = reg1_in;
    w_load.reg2              = reg2_in;
    w_load.dest              = dest_in;
    w_load.src1              = src1_in;
    w_load.src2              = src2_in;
    w_load.b_signed_imm      = b_signed_imm_in;
    w_load.shifter_operand   = shifter_operand_in;
    w_load.carry             = carry_in;
  end

  // Flush outranks freeze: a taken branch must squash even a stalled slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bundle <= ID_EX_BUNDLE_BUBBLE;
    else if (flush)
      r_bundle <= ID_EX_BUNDLE_BUBBLE;
    else if (!freeze)
      r_bundle <= w_load;
  end

  assign w_stall_inc = freeze & ~flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

  assign valid           = r_bundle.valid;
  assign status_en       = r_bundle.ctrl.status_en;
  assign mem_read        = r_bundle.ctrl.mem_read;
  assign mem_write       = r_bundle.ctrl.mem_write;
  assign wb_en           = r_bundle.ctrl.wb_en;
  assign branch          = r_bundle.ctrl.branch;
  assign imm             = r_bundle.ctrl.imm;
  assign alu_cmd         = r_bundle.ctrl.alu_cmd;
  assign pc              = r_bundle.pc;
  assign reg1            = r_bundle.reg1;
  assign reg2            = r_bundle.reg2;
  assign dest            = r_bundle.dest;
  assign src1            = r_bundle.src1;
  assign src2            = r_bundle.src2;
  assign b_signed_imm    = r_bundle.b_signed_imm;
  assign shifter_operand = r_bundle.shifter_operand;
  assign carry           = r_bundle.carry;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: table-driven vectors through a
// scoreboard queue, plus hand sequences for async reset and saturation.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared data inputs
  logic        freeze = 1'b0, flush = 1'b0;
  logic        freeze2 = 1'b0, flush2 = 1'b0;
  logic [31:0] pc_in = '0, reg1_in = '0, reg2_in = '0;
  logic [3:0]  alu_cmd_in = '0, dest_in = '0, src1_in = '0, src2_in = '0;
  logic        status_en_in = 0, mem_read_in = 0, mem_write_in = 0;
  logic        wb_en_in = 0, branch_in = 0, imm_in = 0, carry_in = 0;
  logic [23:0] b_signed_imm_in = '0;
  logic [11:0] shifter_operand_in = '0;

  // Main DUT outputs
  logic [31:0] pc, reg1, reg2;
  logic [3:0]  alu_cmd, dest, src1, src2;
  logic        status_en, mem_read, mem_write, wb_en, branch, imm, carry, valid;
  logic [23:0] b_signed_imm;
  logic [11:0] shifter_operand;
  logic [15:0] stall_cnt, flush_cnt;

  // Narrow-counter DUT outputs
  logic [31:0] d2_pc, d2_reg1, d2_reg2;
  logic [3:0]  d2_alu_cmd, d2_dest, d2_src1, d2_src2;
  logic        d2_status_en, d2_mem_read, d2_mem_write, d2_wb_en, d2_branch;
  logic        d2_imm, d2_carry, d2_valid;
  logic [23:0] d2_b_signed_imm;
  logic [11:0] d2_shifter_operand;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  id_ex_pipe_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
    .alu_cmd_in(alu_cmd_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_en_in(status_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_en_in(wb_en_in), .branch_in(branch_in), .imm_in(imm_in),
    .b_signed_imm_in(b_signed_imm_in), .shifter_operand_in(shifter_operand_in),
    .carry_in(carry_in),
    .pc(pc), .reg1(reg1), .reg2(reg2), .alu_cmd(alu_cmd), .dest(dest),
    .src1(src1), .src2(src2), .status_en(status_en), .mem_read(mem_read),
    .mem_write(mem_write), .wb_en(wb_en), .branch(branch), .imm(imm),
    .b_signed_imm(b_signed_imm), .shifter_operand(shifter_operand), .carry(carry),
    .valid(valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(freeze2), .flush(flush2),
    .pc_in(pc_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
    .alu_cmd_in(alu_cmd_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_en_in(status_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_en_in(wb_en_in), .branch_in(branch_in), .imm_in(imm_in),
    .b_signed_imm_in(b_signed_imm_in), .shifter_operand_in(shifter_operand_in),
    .carry_in(carry_in),
    .pc(d2_pc), .reg1(d2_reg1), .reg2(d2_reg2), .alu_cmd(d2_alu_cmd), .dest(d2_dest),
    .src1(d2_src1), .src2(d2_src2), .status_en(d2_status_en), .mem_read(d2_mem_read),
    .mem_write(d2_mem_write), .wb_en(d2_wb_en), .branch(d2_branch), .imm(d2_imm),
    .b_signed_imm(d2_b_signed_imm), .shifter_operand(d2_shifter_operand), .carry(d2_carry),
    .valid(d2_valid), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Secondary fields are derived from pc_in so every port carries a distinct pattern.
  function automatic logic [80:0] aux_of(input logic [31:0] p);
    logic [3:0] nib;
    nib = p[5:2];
    return {p ^ 32'hA5A5_0000, nib, ~nib, p[2], p[3], p[4], p[5],
            p[23:0] ^ 24'h123456, p[11:0] ^ 12'hABC, ~p[2]};
  endfunction

  function automatic logic [80:0] aux_dut();
    return {reg2, src1, src2, status_en, mem_read, mem_write, imm,
            b_signed_imm, shifter_operand, carry};
  endfunction

  typedef struct {
    logic        frz, fls;
    logic [31:0] pc_i, reg1_i;
    logic [3:0]  alu_i, dest_i;
    logic        wb_i, br_i;
    logic [31:0] e_pc, e_reg1;
    logic [3:0]  e_alu, e_dest;
    logic        e_wb, e_br, e_valid;
    logic [15:0] e_st, e_fl;
  } vec_t;

  typedef struct {
    logic [31:0] pc, reg1;
    logic [3:0]  alu, dest;
    logic        wb, br, valid;
    logic [15:0] st, fl;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  function automatic vec_t mk(input logic frz, fls, input logic [31:0] pci, r1i,
                              input logic [3:0] ai, di, input logic wi, bi,
                              input logic [31:0] ep, er1, input logic [3:0] ea, ed,
                              input logic ew, eb, ev, input logic [15:0] est, efl);
    vec_t v;
    v.frz = frz; v.fls = fls; v.pc_i = pci; v.reg1_i = r1i; v.alu_i = ai; v.dest_i = di;
    v.wb_i = wi; v.br_i = bi; v.e_pc = ep; v.e_reg1 = er1; v.e_alu = ea; v.e_dest = ed;
    v.e_wb = ew; v.e_br = eb; v.e_valid = ev; v.e_st = est; v.e_fl = efl;
    return v;
  endfunction

  task automatic drive_data(input logic [31:0] p, r1, input logic [3:0] a, d,
                            input logic w, b);
    logic [80:0] x;
    x = aux_of(p);
    pc_in = p; reg1_in = r1; alu_cmd_in = a; dest_in = d; wb_en_in = w; branch_in = b;
    {reg2_in, src1_in, src2_in, status_en_in, mem_read_in, mem_write_in, imm_in,
     b_signed_imm_in, shifter_operand_in, carry_in} = x;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".pc"},    pc,        e.pc);
    check({tag, ".reg1"},  reg1,      e.reg1);
    check({tag, ".alu"},   alu_cmd,   e.alu);
    check({tag, ".dest"},  dest,      e.dest);
    check({tag, ".wb"},    wb_en,     e.wb);
    check({tag, ".br"},    branch,    e.br);
    check({tag, ".valid"}, valid,     e.valid);
    check({tag, ".stall"}, stall_cnt, e.st);
    check({tag, ".flush"}, flush_cnt, e.fl);
    check({tag, ".aux"},   aux_dut(), e.valid ? aux_of(e.pc) : 81'd0);
  endtask

  initial begin
    // 0..1 loads, 2..4 stall, 5 release, 6..7 flush, 8..10 flush+freeze then stall on bubble, 11 decode bubble
    vecs[0]  = mk(0,0, 32'h08,32'h5, 4'h2,4'h3,1,0, 32'h08,32'h5, 4'h2,4'h3,1,0,1, 16'd0,16'd0);
    vecs[1]  = mk(0,0, 32'h10,32'h7, 4'h4,4'h1,1,1, 32'h10,32'h7, 4'h4,4'h1,1,1,1, 16'd0,16'd0);
    vecs[2]  = mk(1,0, 32'h14,32'h9, 4'h5,4'h2,0,0, 32'h10,32'h7, 4'h4,4'h1,1,1,1, 16'd1,16'd0);
    vecs[3]  = mk(1,0, 32'h14,32'h9, 4'h5,4'h2,0,0, 32'h10,32'h7, 4'h4,4'h1,1,1,1, 16'd2,16'd0);
    vecs[4]  = mk(1,0, 32'h14,32'h9, 4'h5,4'h2,0,0, 32'h10,32'h7, 4'h4,4'h1,1,1,1, 16'd3,16'd0);
    vecs[5]  = mk(0,0, 32'h14,32'h9, 4'h5,4'h2,0,0, 32'h14,32'h9, 4'h5,4'h2,0,0,1, 16'd3,16'd0);
    vecs[6]  = mk(0,0, 32'h20,32'hA, 4'h1,4'h4,1,1, 32'h20,32'hA, 4'h1,4'h4,1,1,1, 16'd3,16'd0);
    vecs[7]  = mk(0,1, 32'h24,32'hB, 4'h3,4'h5,1,1, 32'h00,32'h0, 4'h0,4'h0,0,0,0, 16'd3,16'd1);
    vecs[8]  = mk(0,0, 32'h24,32'hB, 4'h3,4'h5,1,1, 32'h24,32'hB, 4'h3,4'h5,1,1,1, 16'd3,16'd1);
    vecs[9]  = mk(1,1, 32'h28,32'hC, 4'h6,4'h6,1,0, 32'h00,32'h0, 4'h0,4'h0,0,0,0, 16'd3,16'd2);
    vecs[10] = mk(1,0, 32'h2C,32'hD, 4'h7,4'h7,1,0, 32'h00,32'h0, 4'h0,4'h0,0,0,0, 16'd4,16'd2);
    vecs[11] = mk(0,0, 32'h30,32'hE, 4'h0,4'h0,0,0, 32'h30,32'hE, 4'h0,4'h0,0,0,1, 16'd4,16'd2);

    // Reset state while rst is held across an edge
    drive_data(32'h40, 32'h1, 4'h9, 4'h9, 1, 1);
    @(posedge clk); #1;
    check("rst.pc", pc, 32'h0);
    check("rst.valid", valid, 1'b0);
    check("rst.aux", aux_dut(), 81'd0);
    check("rst.cnts", {stall_cnt, flush_cnt}, 32'h0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      freeze = vecs[i].frz; flush = vecs[i].fls;
      drive_data(vecs[i].pc_i, vecs[i].reg1_i, vecs[i].alu_i, vecs[i].dest_i,
                 vecs[i].wb_i, vecs[i].br_i);
      e.pc = vecs[i].e_pc; e.reg1 = vecs[i].e_reg1; e.alu = vecs[i].e_alu;
      e.dest = vecs[i].e_dest; e.wb = vecs[i].e_wb; e.br = vecs[i].e_br;
      e.valid = vecs[i].e_valid; e.st = vecs[i].e_st; e.fl = vecs[i].e_fl;
      sb.push_back(e);
      @(posedge clk); #1;
      compare_pop($sformatf("vec%0d", i));
    end

    // Inputs changing mid-cycle must not reach outputs
    @(negedge clk);
    freeze = 0; flush = 0;
    drive_data(32'h40, 32'h55, 4'hA, 4'hC, 1, 0);
    @(posedge clk); #1;
    check("load40.pc", pc, 32'h40);
    #2 drive_data(32'h44, 32'h66, 4'hB, 4'hD, 0, 1);
    #1;
    check("nocomb.pc", pc, 32'h40);
    check("nocomb.reg1", reg1, 32'h55);

    // Async reset in the middle of a stall
    @(negedge clk); freeze = 1;
    @(posedge clk); #1;
    check("midstall.cnt", stall_cnt, 16'd5);
    #2 rst = 1'b1;
    #1;
    check("arst.pc", pc, 32'h0);
    check("arst.valid", valid, 1'b0);
    check("arst.stall", stall_cnt, 16'd0);
    check("arst.flush", flush_cnt, 16'd0);
    @(negedge clk); rst = 1'b0; freeze = 0;
    @(posedge clk); #1;
    check("postrst.pc", pc, 32'h44);
    check("postrst.valid", valid, 1'b1);

    // Saturation on the 2-bit counter instance
    @(negedge clk); freeze2 = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat.edge%0d", k + 1), d2_stall_cnt, (k < 3) ? 2'(k + 1) : 2'd3);
    end
    check("sat.flush", d2_flush_cnt, 2'd0);
    check("sat.hold_pc", d2_pc, 32'h44);
    @(negedge clk); freeze2 = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage ARM pipeline.
- Captures every decoded field the decode stage produces: PC, operands, control bits, immediates, destination and source register numbers, and the carry flag.
- Supports freeze (hold) for stalls and flush (bubble) for taken branches.
- Keeps saturating stall and flush event counters for pipeline debug.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- freeze  in  1  hold all register contents this cycle (stall).
- flush  in  1  load a bubble this cycle (taken branch); has priority over freeze.
- pc_in  in  32  PC+4 forwarded by decode.
- reg1_in  in  32  Rn value.
- reg2_in  in  32  Rm value, or Rd value for STR.
- alu_cmd_in  in  4  execute command.
- dest_in  in  4  Rd.
- src1_in  in  4  Rn number (for forwarding).
- src2_in  in  4  Rm/Rd number (for forwarding).
- status_en_in, mem_read_in, mem_write_in, wb_en_in, branch_in, imm_in  in  1 each  decoded control bits.
- b_signed_imm_in  in  24  branch offset.
- shifter_operand_in  in  12  operand2 field.
- carry_in  in  1  C flag from the status register.
- pc, reg1, reg2, alu_cmd, dest, src1, src2, status_en, mem_read, mem_write, wb_en, branch, imm, b_signed_imm, shifter_operand, carry  out  same widths as the matching *_in ports  registered copies.
- valid  out  1  the slot holds a real instruction, not a bubble.
- stall_cnt  out  CNT_W  cycles with freeze=1 and flush=0.
- flush_cnt  out  CNT_W  cycles with flush=1.

Behaviour:
- Reset: asynchronous, active-high. While rst=1, every output is 0, including valid and both counters. The register loads normally on the first rising edge after rst deasserts.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority:
  - flush=1: every data and control field is loaded with 0 and valid=0. This holds regardless of freeze.
  - flush=0, freeze=1: every field holds, valid holds, and stall_cnt increments.
  - flush=0, freeze=0: every field loads from its *_in port and valid=1.
- Bubble from decode: decode already zeroes its control bits on a hazard. Such an input loads with valid=1. valid reflects only the register's own flush; execute gates on the control bits.
- flush_cnt increments on every edge with flush=1.
- Counters saturate at 2^CNT_W-1 and never wrap. A saturated counter holds its value.
- Simultaneous flush and freeze: flush wins, flush_cnt increments, stall_cnt does not.
- Reset mid-stall or mid-flush: outputs clear immediately (asynchronously), and counters clear.
- No combinational path from any input to any output.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU_CMD_W=4, REG_IDX_W=4, WORD_W=32.
  - A packed struct id_ex_ctrl_t with fields status_en, mem_read, mem_write, wb_en, branch, imm, alu_cmd.
  - The constant ID_EX_BUBBLE: all fields zero.
- Sub-module sat_counter, parameterised by width, with ports clk, rst, inc and count. It is instantiated twice, once for stall_cnt and once for flush_cnt.
- The register itself is a single always block over the packed bundle.

Test Plan:
- Reset: assert rst mid-cycle with pc_in=32'h40 already loaded -> pc=0, valid=0 and both counters 0 immediately, before the next clk edge.
- Normal load: pc_in=32'h8, reg1_in=32'h5, alu_cmd_in=4'b0010, wb_en_in=1, dest_in=4'd3, freeze=0, flush=0 -> after one edge pc=32'h8, reg1=32'h5, alu_cmd=2, wb_en=1, dest=3, valid=1.
- Freeze: load pc=32'h10, then hold freeze=1 for 3 edges while pc_in=32'h14 -> pc stays 32'h10 and stall_cnt=3. Drop freeze -> pc=32'h14 after the next edge.
- Flush: register holding branch=1, wb_en=1; assert flush for 1 edge -> all outputs 0, valid=0, flush_cnt=1.
- Flush plus freeze on the same edge -> bubble loaded, flush_cnt=1, stall_cnt unchanged.
- Saturation with CNT_W=2: 5 consecutive freeze edges -> stall_cnt reads 3 after the 3rd edge and stays 3.
